cpu_multicycle_ctrl: RTL



---
 rtl/cpu_ctrl_pkg.sv | 59 +++++
 rtl/cpu_multicycle_ctrl_mem_wait_ctr.sv | 20 ++
 rtl/cpu_multicycle_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: state numbers, opcode
// classes, default ALU ops and datapath mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BEQ       = 4'd8,
    S_JMP       = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_HALT      = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    C_R    = 3'b000,
    C_I    = 3'b001,
    C_LWI  = 3'b010,
    C_SWI  = 3'b011,
    C_BEQ  = 3'b100,
    C_JMP  = 3'b101,
    C_ILL  = 3'b110,
    C_HALT = 3'b111
  } class_e;

  localparam logic [2:0] ADD_OP_DEF = 3'b010;
  localparam logic [2:0] SUB_OP_DEF = 3'b011;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       r1_or_r3;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } ctl_t;

endpackage

// File: rtl/cpu_multicycle_ctrl_mem_wait_ctr.sv
// Memory-access wait counter: counts 0..MEM_LAT-1 and saturates, done marks
// the last cycle of an access. Cleared synchronously on clr_i.
module mem_wait_ctr #(
  parameter int MEM_LAT = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  output logic done_o
);
  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  logic [3:0] cnt_q;

  assign done_o = (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (clr_i)        cnt_q <= '0;
    else if (!done_o) cnt_q <= cnt_q + 4'd1;
  end
endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multicycle control FSM for CPU_Datapath. Optional illegal-opcode trap is
// enabled by defining CPU_CTRL_ILLEGAL_TRAP_EN.
module cpu_multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int MEM_LAT  = 1,
  parameter logic [ALUOP_W-1:0] ADD_OP = ALUOP_W'(ADD_OP_DEF),
  parameter logic [ALUOP_W-1:0] SUB_OP = ALUOP_W'(SUB_OP_DEF)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Out_to_Control,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic                R1orR3,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                Halted,
  output logic                Illegal,
  output logic [3:0]          State_dbg
);
  state_e               state_q, state_d;
  class_e               cls;
  logic [ALUOP_W-1:0]   func;
  logic                 wait_done, wait_clr;
  ctl_t                 ctl;
  logic [ALUOP_W-1:0]   alu_op;

  assign cls  = class_e'(Out_to_Control[OPCODE_W-1 -: 3]);
  assign func = Out_to_Control[ALUOP_W-1:0];

  assign wait_clr = Reset || (state_d != state_q);

  mem_wait_ctr #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk_i  (Clk),
    .clr_i  (wait_clr),
    .done_o (wait_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        case (cls)
          C_R:         state_d = S_R_EXEC;
          C_I:         state_d = S_I_EXEC;
          C_LWI, C_SWI: state_d = S_MEM_ADDR;
          C_BEQ:       state_d = S_BEQ;
          C_JMP:       state_d = S_JMP;
          C_HALT:      state_d = S_HALT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          C_ILL:       state_d = S_TRAP;
`else
          C_ILL:       state_d = S_FETCH;
`endif
          default:     state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (cls == C_SWI) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (wait_done) state_d = S_MEM_WB;
      S_MEM_WRITE: if (wait_done) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_HALT, S_TRAP: state_d = state_q;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Outputs decode straight from state so Reset can blank them in the same cycle.
  always_comb begin
    ctl    = '0;
    alu_op = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.pc_source = PCSRC_ALU;
        ctl.pc_write  = wait_done;
        ctl.ir_write  = wait_done;
        alu_op        = ADD_OP;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_SHIMM;
        alu_op        = ADD_OP;
      end
      S_MEM_ADDR, S_MEM_READ, S_MEM_WRITE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.mem_read  = (state_q == S_MEM_READ);
        ctl.mem_write = (state_q == S_MEM_WRITE);
        alu_op        = ADD_OP;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_R_EXEC, S_R_WB: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.reg_write = (state_q == S_R_WB);
        alu_op        = func;
      end
      S_I_EXEC, S_I_WB: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.r1_or_r3  = 1'b1;
        ctl.reg_write = (state_q == S_I_WB);
        alu_op        = func;
      end
      S_BEQ: begin
        ctl.pc_write_cond = 1'b1;
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_REG;
        ctl.pc_source     = PCSRC_ALUOUT;
        alu_op            = SUB_OP;
      end
      S_JMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
    if (Reset) begin
      ctl    = '0;
      alu_op = '0;
    end
  end

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign IRWrite     = ctl.ir_write;
  assign R1orR3      = ctl.r1_or_r3;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign PCSource    = ctl.pc_source;
  assign ALUOp       = alu_op;
  assign Halted      = !Reset && (state_q == S_HALT);
  assign State_dbg   = Reset ? 4'd0 : state_q;

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  assign Illegal = !Reset && (state_q == S_TRAP);
`else
  assign Illegal = 1'b0;
`endif

endmodule
